// File: rtl/noc_traffic_gen_if.sv
// Flit channel between a traffic generator (master) and a router input port (slave).
// stop_in is the router's back-pressure; data_void_out marks an empty slot.
interface noc_traffic_gen_if #(
  parameter int unsigned WORD_WIDTH = 32
);
  logic [WORD_WIDTH-1:0] data_out;
  logic                  data_void_out;
  logic                  stop_in;

  modport master (
    output data_out,
    output data_void_out,
    input  stop_in
  );

  modport slave (
    input  data_out,
    input  data_void_out,
    output stop_in
  );
endinterface

// File: rtl/noc_traffic_gen.sv
// NoC traffic generator: LFSR-paced head/body/tail packet injection with XY lookahead.
// Optional macro TRAFFIC_GEN_TIMESTAMP_EN: first body flit carries the decision-edge cycle count.
module noc_traffic_gen #(
  parameter int unsigned WORD_WIDTH = 32,
  parameter int unsigned X_BITS     = 3,
  parameter int unsigned Y_BITS     = 3,
  parameter int unsigned MESH_X     = 4,
  parameter int unsigned MESH_Y     = 4,
  parameter int unsigned SRC_X      = 0,
  parameter int unsigned SRC_Y      = 0,
  parameter logic [15:0] SEED       = 16'hACE1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     enable,
  input  logic [7:0]               rate,
  input  logic [1:0]               dest_mode,
  input  logic [X_BITS-1:0]        fixed_x,
  input  logic [Y_BITS-1:0]        fixed_y,
  input  logic [3:0]               pkt_len,
  input  logic [15:0]              num_pkts,
  noc_traffic_gen_if.master        flit_if,
  output logic                     done,
  output logic [15:0]              pkt_count
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_HEAD = 3'd1,
    ST_BODY = 3'd2,
    ST_TAIL = 3'd3,
    ST_DONE = 3'd4
  } state_e;

  localparam logic [X_BITS-1:0] SRC_XB = X_BITS'(SRC_X);
  localparam logic [Y_BITS-1:0] SRC_YB = Y_BITS'(SRC_Y);

  state_e                state_q, state_d;
  logic [15:0]           lfsr_q, lfsr_d;
  logic [WORD_WIDTH-1:0] data_q, data_d;
  logic                  void_q, void_d;
  logic                  done_q, done_d;
  logic [15:0]           count_q, count_d;
  logic [15:0]           seq_q, seq_d;
  logic [3:0]            len_q, len_d;
  logic [3:0]            idx_q, idx_d;
  logic [X_BITS-1:0]     cand_x_s;
  logic [Y_BITS-1:0]     cand_y_s;
  logic                  dest_ok_s;
  logic                  rate_ok_s;
  logic                  inject_s;
  logic                  xfer_s;
`ifdef TRAFFIC_GEN_TIMESTAMP_EN
  logic [31:0]           cycle_q;
  logic [31:0]           stamp_q, stamp_d;
`endif

  function automatic logic [4:0] lookahead(input logic [X_BITS-1:0] dx, input logic [Y_BITS-1:0] dy);
    logic [4:0] la;
    if (dx > SRC_XB) begin
      la = 5'b00010;
    end else if (dx < SRC_XB) begin
      la = 5'b00100;
    end else if (dy > SRC_YB) begin
      la = 5'b01000;
    end else if (dy < SRC_YB) begin
      la = 5'b10000;
    end else begin
      la = 5'b00001;
    end
    return la;
  endfunction

  function automatic logic [WORD_WIDTH-1:0] mk_head(input logic [X_BITS-1:0] dx, input logic [Y_BITS-1:0] dy);
    logic [WORD_WIDTH-1:0] w;
    w = '0;
    w[WORD_WIDTH-1 -: 2]             = 2'b10;
    w[WORD_WIDTH-9 -: X_BITS]        = dx;
    w[WORD_WIDTH-9-X_BITS -: Y_BITS] = dy;
    w[4:0]                           = lookahead(dx, dy);
    return w;
  endfunction

  function automatic logic [WORD_WIDTH-1:0] mk_body(input logic [15:0] seq, input logic [7:0] idx);
    logic [WORD_WIDTH-1:0] w;
    w = '0;
    w[23:8] = seq;
    w[7:0]  = idx;
    return w;
  endfunction

  function automatic logic [WORD_WIDTH-1:0] mk_tail();
    logic [WORD_WIDTH-1:0] w;
    w = '0;
    w[WORD_WIDTH-1 -: 2]     = 2'b01;
    w[6 +: Y_BITS]           = SRC_YB;
    w[6 + Y_BITS +: X_BITS]  = SRC_XB;
    return w;
  endfunction

`ifdef TRAFFIC_GEN_TIMESTAMP_EN
  function automatic logic [WORD_WIDTH-1:0] mk_stamp(input logic [31:0] stamp);
    logic [WORD_WIDTH-1:0] w;
    w = WORD_WIDTH'(stamp);
    w[WORD_WIDTH-1 -: 2] = 2'b00;
    return w;
  endfunction
`endif

  // Galois LFSR, x^16+x^14+x^13+x^11+1, shifting right.
  assign lfsr_d    = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
  assign rate_ok_s = (rate == 8'hFF) || (lfsr_q[7:0] < rate);
  assign inject_s  = enable && !done_q && rate_ok_s && dest_ok_s;
  assign xfer_s    = !void_q && !flit_if.stop_in;

  // Candidate destination for this cycle's injection decision and its validity.
  always_comb begin
    cand_x_s = fixed_x;
    cand_y_s = fixed_y;
    case (dest_mode)
      2'd0: begin
        cand_x_s = lfsr_q[8 +: X_BITS];
        cand_y_s = lfsr_q[12 +: Y_BITS];
      end
      2'd2: begin
        cand_x_s = X_BITS'(SRC_Y);
        cand_y_s = Y_BITS'(SRC_X);
      end
      default: begin
        cand_x_s = fixed_x;
        cand_y_s = fixed_y;
      end
    endcase
    if (dest_mode == 2'd0) begin
      dest_ok_s = (32'(cand_x_s) < MESH_X) && (32'(cand_y_s) < MESH_Y) &&
                  !((cand_x_s == SRC_XB) && (cand_y_s == SRC_YB));
    end else begin
      dest_ok_s = 1'b1;
    end
  end

  // Packet FSM: next state and next registered flit, advancing only on a transfer.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    void_d  = void_q;
    done_d  = done_q;
    count_d = count_q;
    seq_d   = seq_q;
    len_d   = len_q;
    idx_d   = idx_q;
`ifdef TRAFFIC_GEN_TIMESTAMP_EN
    stamp_d = stamp_q;
`endif
    case (state_q)
      ST_IDLE: begin
        void_d = 1'b1;
        data_d = '0;
        if (inject_s) begin
          state_d = ST_HEAD;
          data_d  = mk_head(cand_x_s, cand_y_s);
          void_d  = 1'b0;
          seq_d   = count_q;
          len_d   = pkt_len;
          idx_d   = 4'd0;
`ifdef TRAFFIC_GEN_TIMESTAMP_EN
          stamp_d = cycle_q;
`endif
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_HEAD: begin
        if (xfer_s) begin
          if (len_q == 4'd0) begin
            state_d = ST_TAIL;
            data_d  = mk_tail();
          end else begin
            state_d = ST_BODY;
            idx_d   = 4'd0;
`ifdef TRAFFIC_GEN_TIMESTAMP_EN
            data_d  = mk_stamp(stamp_q);
`else
            data_d  = mk_body(seq_q, 8'd0);
`endif
          end
        end else begin
          state_d = ST_HEAD;
        end
      end
      ST_BODY: begin
        if (xfer_s) begin
          if (idx_q == (len_q - 4'd1)) begin
            state_d = ST_TAIL;
            data_d  = mk_tail();
          end else begin
            idx_d  = idx_q + 4'd1;
            data_d = mk_body(seq_q, {4'd0, idx_q + 4'd1});
          end
        end else begin
          state_d = ST_BODY;
        end
      end
      ST_TAIL: begin
        if (xfer_s) begin
          count_d = (count_q == 16'hFFFF) ? count_q : count_q + 16'd1;
          void_d  = 1'b1;
          data_d  = '0;
          if ((num_pkts != 16'd0) && (count_d == num_pkts)) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          state_d = ST_TAIL;
        end
      end
      ST_DONE: begin
        void_d = 1'b1;
        data_d = '0;
        done_d = 1'b1;
      end
      default: begin
        state_d = ST_IDLE;
        void_d  = 1'b1;
        data_d  = '0;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      lfsr_q  <= SEED;
      data_q  <= '0;
      void_q  <= 1'b1;
      done_q  <= 1'b0;
      count_q <= 16'd0;
      seq_q   <= 16'd0;
      len_q   <= 4'd0;
      idx_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      data_q  <= data_d;
      void_q  <= void_d;
      done_q  <= done_d;
      count_q <= count_d;
      seq_q   <= seq_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
    end
  end

`ifdef TRAFFIC_GEN_TIMESTAMP_EN
  // Free-running cycle counter and the stamp latched at the decision edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cycle_q <= 32'd0;
      stamp_q <= 32'd0;
    end else begin
      cycle_q <= cycle_q + 32'd1;
      stamp_q <= stamp_d;
    end
  end
`endif

  assign flit_if.data_out      = data_q;
  assign flit_if.data_void_out = void_q;
  assign done                  = done_q;
  assign pkt_count             = count_q;

endmodule
